ray_dispatcher: RTL
===================

// Module: ray_dispatcher
// PURPOSE
//  Primary-ray transmitter for the ray core. Scans the frame in raster order and hands one
//  SurfaceInputData per pixel to the core's input FIFO via add_input/fifo_full.
//  Counts core completions (valid) to detect frame end. Sits between frame control and the core.
// PARAMETERS
//  FRAME_W        160  pixels per line (>=1)
//  FRAME_H        120  lines per frame (>=1)
//  RAYGEN_LAT     4    fixed pipeline latency of primary_ray_gen, in cycles (>=1)
//  SKID_DEPTH     8    skid FIFO entries; must be >= RAYGEN_LAT+1
// PORTS
//  clk           in   1     clock
//  resetn        in   1     async active-low reset
//  start         in   1     pulse: begin a frame (ignored unless IDLE)
//  rs            in   RenderState  camera/render state; sampled every cycle by primary_ray_gen
//  fifo_full     in   1     core input FIFO full (level)
//  add_input     out  1     push strobe to core, one item per high cycle
//  input_data    out  SurfaceInputData  item being pushed; valid only when add_input=1
//  core_valid    in   1     core's shade-output valid; one pulse per finished pixel
//  busy          out  1     high from accepted start until frame_done
//  frame_done    out  1     one-cycle pulse when all FRAME_W*FRAME_H results have returned
//  issued_cnt    out  $clog2(FRAME_W*FRAME_H+1)  pixels pushed to core this frame
// BEHAVIOUR
//  Reset: state=IDLE; add_input=0, busy=0, frame_done=0, issued_cnt=0, x=y=0, skid empty,
//   in-flight=0, returned=0; input_data=0. Reset mid-frame abandons the frame; no further push.
//  FSM: IDLE -start-> GEN; GEN -last pixel (x=FRAME_W-1,y=FRAME_H-1) sent to raygen-> DRAIN;
//   DRAIN -skid empty & in-flight=0-> WAIT; WAIT -returned=FRAME_W*FRAME_H-> DONE;
//   DONE -> IDLE after 1 cycle (frame_done=1 in DONE only). start outside IDLE is ignored.
//  Generation: in GEN, a pixel (x,y) enters primary_ray_gen when
//   skid_count + inflight_count + 1 <= SKID_DEPTH (credit rule); then x++, wrap to 0 with y++.
//   Result emerges exactly RAYGEN_LAT cycles later and is written to the skid FIFO.
//   Credit rule guarantees the skid FIFO never overflows; overflow is a fatal assertion.
//  Push handshake: add_input = !skid_empty & !fifo_full (combinational on fifo_full);
//   input_data = skid head (first-word-fall-through). Pop on add_input. Never assert
//   add_input while fifo_full=1. Order of pushes = raster order, no gaps, no duplicates.
//  Simultaneous skid write and pop in the same cycle: count unchanged, both take effect.
//  Fields filled: pixel x,y from scan counters, bounce level 0, primary ray from
//   primary_ray_gen; all other SurfaceInputData fields zero.
//  Counters: issued_cnt increments on add_input; returned increments on core_valid in any
//   non-IDLE state; core_valid in IDLE is ignored. returned and issued_cnt clear on accepted start.
//  Widths: x is $clog2(FRAME_W), y is $clog2(FRAME_H) (min 1 bit); counters saturate never
//   (returned > FRAME_W*FRAME_H is a fatal assertion).
//  busy = state != IDLE (DONE included).
//  Latency: start at cycle 0 -> first add_input at cycle RAYGEN_LAT+1 if fifo_full=0.
// STRUCTURE
//  Shared package: SurfaceInputData, RenderState, Ray typedefs and pixel coordinate widths
//   already in the common package; add dispatcher state enum there.
//  Sub-module primary_ray_gen (fixed-latency, fully pipelined, valid shifted alongside data)
//   builds the camera ray from (x,y,rs). Skid FIFO and FSM live in ray_dispatcher.
// TESTING
//  FRAME_W=4,FRAME_H=2, fifo_full=0, core echoes valid 10 cycles after push -> 8 pushes in
//   raster order (0,0)..(3,1), first push at cycle RAYGEN_LAT+1, frame_done once after 8th return.
//  fifo_full held high for 20 cycles mid-frame -> add_input stays 0, skid fills to <=SKID_DEPTH,
//   no pixel lost; pushes resume next cycle fifo_full drops.
//  Random fifo_full toggling (50%), FRAME_W=5,FRAME_H=3 -> exactly 15 pushes, sequence equals
//   raster scoreboard, never add_input&fifo_full.
//  start pulsed while busy -> ignored; issued_cnt not cleared; frame still ends at 8 returns.
//  resetn asserted mid-GEN -> outputs at reset values immediately; new start runs a clean frame
//   from (0,0).
//  FRAME_W=1,FRAME_H=1 -> single push (0,0), frame_done one cycle after its core_valid.

Source files
------------

// File: rtl/ray_dispatcher_pkg.sv
// ray_dispatcher_pkg: ray core shared types plus the dispatcher state encoding.
package ray_dispatcher_pkg;

   localparam int PIX_W  = 12;
   localparam int COMP_W = 16;

   typedef logic [COMP_W-1:0] comp_t;

   typedef struct packed {
      comp_t ox, oy, oz;
      comp_t dx, dy, dz;
   } ray_t;

   typedef struct packed {
      ray_t  cam;
      comp_t step_x, step_y;
   } render_state_t;

   typedef struct packed {
      logic [PIX_W-1:0] px, py;
      logic [1:0]       bounce;
      ray_t             ray;
      comp_t            throughput;
      logic [7:0]       material;
      logic             hit;
   } surface_input_data_t;

   typedef enum logic [2:0] {S_IDLE, S_GEN, S_DRAIN, S_WAIT, S_DONE} disp_state_t;

   // Camera ray through pixel (x,y): origin at the camera, direction stepped per pixel.
   function automatic ray_t make_ray(comp_t x, comp_t y, render_state_t rs);
      ray_t r;
      r = rs.cam;
      r.dx = rs.cam.dx + x * rs.step_x;
      r.dy = rs.cam.dy + y * rs.step_y;
      return r;
   endfunction

endpackage

// File: rtl/ray_dispatcher_primary_ray_gen.sv
// ray_dispatcher_primary_ray_gen: fixed-latency, fully pipelined camera ray builder;
// the valid bit and pixel coordinates travel alongside the ray.
module ray_dispatcher_primary_ray_gen
   import ray_dispatcher_pkg::*;
#(
   parameter int XW  = 8,
   parameter int YW  = 7,
   parameter int LAT = 4
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          req,
   input  logic [XW-1:0] px,
   input  logic [YW-1:0] py,
   input  render_state_t rs,
   output logic          ray_valid,
   output logic [XW-1:0] ray_px,
   output logic [YW-1:0] ray_py,
   output ray_t          ray
);

   typedef struct packed {
      logic          v;
      logic [XW-1:0] x;
      logic [YW-1:0] y;
      ray_t          r;
   } stage_t;

   stage_t pipe [LAT];

   always_ff @(posedge clk or negedge resetn)
      if (!resetn) pipe <= '{default: '0};
      else begin
         pipe[0] <= '{v: req, x: px, y: py, r: make_ray(COMP_W'(px), COMP_W'(py), rs)};
         for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
      end

   assign ray_valid = pipe[LAT-1].v;
   assign ray_px    = pipe[LAT-1].x;
   assign ray_py    = pipe[LAT-1].y;
   assign ray       = pipe[LAT-1].r;

endmodule

// File: rtl/ray_dispatcher.sv
// ray_dispatcher: raster-scans a frame into the ray core input FIFO through a credit-guarded
// skid FIFO and counts core completions to detect frame end.
module ray_dispatcher
   import ray_dispatcher_pkg::*;
#(
   parameter int FRAME_W    = 160,
   parameter int FRAME_H    = 120,
   parameter int RAYGEN_LAT = 4,
   parameter int SKID_DEPTH = 8
) (
   input  logic                                  clk,
   input  logic                                  resetn,
   input  logic                                  start,
   input  render_state_t                         rs,
   input  logic                                  fifo_full,
   output logic                                  add_input,
   output surface_input_data_t                   input_data,
   input  logic                                  core_valid,
   output logic                                  busy,
   output logic                                  frame_done,
   output logic [$clog2(FRAME_W*FRAME_H+1)-1:0]  issued_cnt
);

   localparam int TOTAL = FRAME_W * FRAME_H;
   localparam int XW    = FRAME_W > 1 ? $clog2(FRAME_W) : 1;
   localparam int YW    = FRAME_H > 1 ? $clog2(FRAME_H) : 1;
   localparam int CW    = $clog2(TOTAL + 1);
   localparam int SW    = $clog2(SKID_DEPTH + 1);
   localparam int PW    = SKID_DEPTH > 1 ? $clog2(SKID_DEPTH) : 1;
   localparam int IW    = $clog2(RAYGEN_LAT + 1);

   disp_state_t         state;
   logic [XW-1:0]       x, gen_x;
   logic [YW-1:0]       y, gen_y;
   logic [SW-1:0]       skid_count;
   logic [IW-1:0]       inflight;
   logic [PW-1:0]       wr_ptr, rd_ptr;
   logic [CW-1:0]       returned, returned_next;
   surface_input_data_t skid [SKID_DEPTH];
   surface_input_data_t wr_data;
   ray_t                gen_ray;
   logic                accept, issue, last_x, last_px, gen_valid;

   // The first pixel enters ray generation on the accepting start edge itself.
   assign accept        = state == S_IDLE && start;
   assign last_x        = x == XW'(FRAME_W - 1);
   assign last_px       = last_x && y == YW'(FRAME_H - 1);
   assign issue         = (accept || state == S_GEN) && int'(skid_count) + int'(inflight) < SKID_DEPTH;
   assign add_input     = skid_count != '0 && !fifo_full;
   assign input_data    = skid_count != '0 ? skid[rd_ptr] : '0;
   assign returned_next = returned + CW'(core_valid);

   ray_dispatcher_primary_ray_gen #(.XW(XW), .YW(YW), .LAT(RAYGEN_LAT)) primary_ray_gen (
      .clk       (clk),
      .resetn    (resetn),
      .req       (issue),
      .px        (x),
      .py        (y),
      .rs        (rs),
      .ray_valid (gen_valid),
      .ray_px    (gen_x),
      .ray_py    (gen_y),
      .ray       (gen_ray)
   );

   always_comb begin
      wr_data     = '0;
      wr_data.px  = PIX_W'(gen_x);
      wr_data.py  = PIX_W'(gen_y);
      wr_data.ray = gen_ray;
   end

   always_ff @(posedge clk)
      if (gen_valid) skid[wr_ptr] <= wr_data;

   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         state      <= S_IDLE;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         x          <= '0;
         y          <= '0;
         skid_count <= '0;
         inflight   <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         returned   <= '0;
         issued_cnt <= '0;
      end else begin
         if (issue) begin
            x <= last_x ? '0 : x + XW'(1);
            if (last_x) y <= y == YW'(FRAME_H - 1) ? '0 : y + YW'(1);
         end
         inflight   <= inflight + IW'(issue) - IW'(gen_valid);
         skid_count <= skid_count + SW'(gen_valid) - SW'(add_input);
         if (gen_valid) wr_ptr <= wr_ptr == PW'(SKID_DEPTH - 1) ? '0 : wr_ptr + PW'(1);
         if (add_input) rd_ptr <= rd_ptr == PW'(SKID_DEPTH - 1) ? '0 : rd_ptr + PW'(1);
         issued_cnt <= accept ? '0 : issued_cnt + CW'(add_input);
         returned   <= accept ? '0 : state != S_IDLE ? returned_next : returned;
         frame_done <= 1'b0;
         case (state)
            S_IDLE:  if (start) begin
                        state <= issue && last_px ? S_DRAIN : S_GEN;
                        busy  <= 1'b1;
                     end
            S_GEN:   if (issue && last_px) state <= S_DRAIN;
            S_DRAIN: if (skid_count == '0 && inflight == '0) state <= S_WAIT;
            S_WAIT:  if (returned_next == CW'(TOTAL)) begin
                        state      <= S_DONE;
                        frame_done <= 1'b1;
                     end
            default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                     end
         endcase
      end

   assert property (@(posedge clk) disable iff (!resetn)
      !(gen_valid && !add_input && int'(skid_count) == SKID_DEPTH))
      else $fatal(1, "skid fifo overflow");

   assert property (@(posedge clk) disable iff (!resetn)
      !(core_valid && state != S_IDLE && returned == CW'(TOTAL)))
      else $fatal(1, "more completions than pixels");

endmodule
